// File: rtl/dap_seq_engine.sv
// SWJ/SWD/JTAG bit-sequence engine: shifts up to DATA_W bits LSB-first on SWDIO/TMS or TDI
// with an internally divided SWCLK/TCK, optionally capturing SWDIO or TDO into a response word.
module dap_seq_engine #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 7,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic              cmd_tms,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              SWCLK_TCK_O,
  output logic              SWDIO_TMS_T,
  output logic              SWDIO_TMS_O,
  input  logic              SWDIO_TMS_I,
  input  logic              SWO_TDO_I,
  output logic              TDI_O
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] M_SWJ  = 2'd0;
  localparam logic [1:0] M_SWD  = 2'd1;
  localparam logic [1:0] M_JTAG = 2'd2;
  localparam logic [1:0] M_RSVD = 2'd3;

  logic [1:0]        state;
  logic [1:0]        mode;
  logic              tms;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  phase;
  logic [DATA_W-1:0] shreg;

  logic [IDX_W-1:0]  eff_last;
  logic [1:0]        d_mode;
  logic              d_bit;
  logic              d_tms;
  logic              nx_t;
  logic              nx_o;
  logic              nx_tdi;
  logic              sample_bit;

  // Count 0 and counts above DATA_W both mean a full DATA_W-bit sequence.
  always_comb begin
    eff_last = IDX_W'(DATA_W - 1);
    if (cmd_count != '0 && cmd_count <= CNT_W'(DATA_W))
      eff_last = IDX_W'(cmd_count - CNT_W'(1));
  end

  // Pad values for the bit about to be launched: the incoming command at accept,
  // otherwise the next bit of the latched shift register.
  always_comb begin
    if (state == S_IDLE) begin
      d_mode = cmd_mode;
      d_bit  = cmd_data[0];
      d_tms  = cmd_tms;
    end else begin
      d_mode = mode;
      d_bit  = shreg[0];
      d_tms  = tms;
    end
    nx_t   = SWDIO_TMS_T;
    nx_o   = SWDIO_TMS_O;
    nx_tdi = TDI_O;
    case (d_mode)
      M_SWJ: begin
        nx_o = d_bit;
        nx_t = 1'b0;
      end
      M_SWD: nx_t = 1'b1;
      M_JTAG: begin
        nx_tdi = d_bit;
        nx_o   = d_tms;
        nx_t   = 1'b0;
      end
      default: ;
    endcase
  end

  assign sample_bit = (mode == M_SWD) ? SWDIO_TMS_I : SWO_TDO_I;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      SWCLK_TCK_O <= 1'b0;
      SWDIO_TMS_T <= 1'b1;
      SWDIO_TMS_O <= 1'b0;
      TDI_O       <= 1'b1;
      mode        <= M_SWJ;
      tms         <= 1'b0;
      idx         <= '0;
      last_idx    <= '0;
      div         <= '0;
      phase       <= '0;
      shreg       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            mode      <= cmd_mode;
            tms       <= cmd_tms;
            last_idx  <= eff_last;
            div       <= clk_div;
            idx       <= '0;
            phase     <= '0;
            shreg     <= cmd_data >> 1;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_mode == M_RSVD) begin
              state     <= S_RESP;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              state       <= S_LOW;
              rsp_err     <= 1'b0;
              SWDIO_TMS_T <= nx_t;
              SWDIO_TMS_O <= nx_o;
              TDI_O       <= nx_tdi;
            end
          end
        end
        S_LOW: begin
          if (phase == div) begin
            phase       <= '0;
            state       <= S_HIGH;
            SWCLK_TCK_O <= 1'b1;
          end else begin
            phase <= phase + DIV_W'(1);
          end
        end
        S_HIGH: begin
          // Capture on the first high cycle only; with div=0 this is also the exit cycle.
          if (phase == '0 && mode != M_SWJ)
            rsp_data[idx] <= sample_bit;
          if (phase == div) begin
            phase       <= '0;
            SWCLK_TCK_O <= 1'b0;
            if (idx == last_idx) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              idx         <= idx + IDX_W'(1);
              state       <= S_LOW;
              shreg       <= shreg >> 1;
              SWDIO_TMS_T <= nx_t;
              SWDIO_TMS_O <= nx_o;
              TDI_O       <= nx_tdi;
            end
          end else begin
            phase <= phase + DIV_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
